spi_xfer_sequencer: RTL and testbench

- Upstream feeder for the SPI master-with-chip-select wrapper.
- Host software or an FSM preloads TX bytes into an internal FIFO, then issues a start with a byte length.
- The block streams exactly that many bytes to the wrapper with a DV/Ready handshake and collects every MISO byte into an RX FIFO.
- It reports busy, done and error status back to the host.

---
 rtl/spi_seq_pkg.sv | 19 +
 rtl/spi_sync_fifo.sv | 60 ++++++
 rtl/spi_xfer_sequencer.sv | 178 +++++++++++++++++
 tb/tb_spi_xfer_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared state encoding and width helpers for the SPI transfer sequencer.
package spi_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_RX = 2'd2,
    DONE    = 2'd3
  } state_e;

  function automatic int cw_f(input int max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

  function automatic int lw_f(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// 8-bit first-word-fall-through synchronous FIFO with occupancy output and a
// bulk-discard port used to drop queued entries in a single cycle.
module spi_sync_fifo
  import spi_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LW    = lw_f(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_i,
  input  logic [7:0]    data_i,
  input  logic          rd_i,
  input  logic [LW-1:0] drop_i,
  output logic [7:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  // Head reads as zero while empty so the output is defined straight out of reset.
  assign data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  // A simultaneous push and pop always both proceed, even when full or empty.
  always_comb begin
    push     = wr_i && (!full_o || rd_i);
    pop      = rd_i && (!empty_o || wr_i);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop) + AW'(drop_i);
    level_d  = level_q + LW'(push) - LW'(pop) - drop_i;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Streams preloaded TX bytes to the SPI chip-select wrapper and collects MISO
// bytes into an RX FIFO. Define SPI_SEQ_TIMEOUT_EN to build in the watchdog.
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int FIFO_DEPTH       = 8,
  parameter int TIMEOUT_CLKS     = 4096,
  parameter int CW               = cw_f(MAX_BYTES_PER_CS),
  parameter int LW               = lw_f(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_tx_wr,
  input  logic [7:0]    i_tx_data,
  output logic          o_tx_full,
  output logic [LW-1:0] o_tx_level,
  input  logic          i_start,
  input  logic [CW-1:0] i_len,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  input  logic          i_rx_rd,
  output logic [7:0]    o_rx_data,
  output logic          o_rx_empty,
  output logic [LW-1:0] o_rx_level,
  output logic          o_rx_ovf,
  output logic [CW-1:0] o_MOSI_Count,
  output logic [7:0]    o_MOSI_Byte,
  output logic          o_MOSI_DV,
  input  logic          i_MOSI_Ready,
  input  logic          i_MISO_DV,
  input  logic [7:0]    i_MISO_Byte
);

  state_e        state_q, state_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] sent_q, sent_d;
  logic [CW-1:0] rcvd_q, rcvd_d;
  logic          dv_q;
  logic          ovf_q, ovf_d;
  logic          accept, rx_active, rx_push, dv_fire, timeout;
  logic          rx_full, tx_empty_unused;
  logic [LW-1:0] tx_flush;

  assign rx_active = (state_q == SEND) || (state_q == WAIT_RX);
  assign rx_push   = rx_active && i_MISO_DV;
  // dv_q enforces at least one idle cycle between DV pulses.
  assign dv_fire   = (state_q == SEND) && i_MOSI_Ready && (sent_q < len_q) && !dv_q;
  assign accept    = (i_len != '0) && (i_len <= CW'(MAX_BYTES_PER_CS)) &&
                     (o_tx_level >= LW'(i_len));

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] wd_q, wd_d;

  assign timeout  = rx_active && !dv_fire && !rx_push && (wd_q == TW'(TIMEOUT_CLKS - 1));
  assign tx_flush = timeout ? LW'(len_q - sent_q) : '0;

  always_comb begin
    wd_d = '0;
    if (rx_active && !dv_fire && !rx_push && !timeout) wd_d = wd_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CLKS == 0);
  assign timeout  = 1'b0;
  assign tx_flush = '0;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sent_d  = sent_q;
    rcvd_d  = rcvd_q;
    ovf_d   = ovf_q;
    o_done  = 1'b0;
    o_err   = 1'b0;

    if (rx_push) begin
      if (rcvd_q < len_q) rcvd_d = rcvd_q + CW'(1);
      if (rx_full && !i_rx_rd) ovf_d = 1'b1;
    end
    if (dv_fire) sent_d = sent_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (accept) begin
            len_d   = i_len;
            sent_d  = '0;
            rcvd_d  = '0;
            ovf_d   = 1'b0;
            state_d = SEND;
          end else begin
            o_err = 1'b1;
          end
        end
      end
      SEND: begin
        if (timeout) begin
          o_err   = 1'b1;
          state_d = IDLE;
        end else if (sent_q == len_q) begin
          state_d = WAIT_RX;
        end
      end
      WAIT_RX: begin
        if (rcvd_q == len_q) begin
          state_d = DONE;
        end else if (timeout) begin
          o_err   = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      sent_q  <= '0;
      rcvd_q  <= '0;
      dv_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sent_q  <= sent_d;
      rcvd_q  <= rcvd_d;
      dv_q    <= dv_fire;
      ovf_q   <= ovf_d;
    end
  end

  assign o_busy       = (state_q != IDLE);
  assign o_MOSI_DV    = dv_fire;
  assign o_MOSI_Count = len_q;
  assign o_rx_ovf     = ovf_q;

  spi_sync_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_i    (i_tx_wr),
    .data_i  (i_tx_data),
    .rd_i    (dv_fire),
    .drop_i  (tx_flush),
    .data_o  (o_MOSI_Byte),
    .full_o  (o_tx_full),
    .empty_o (tx_empty_unused),
    .level_o (o_tx_level)
  );

  spi_sync_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_i    (rx_push),
    .data_i  (i_MISO_Byte),
    .rd_i    (i_rx_rd),
    .drop_i  ('0),
    .data_o  (o_rx_data),
    .full_o  (rx_full),
    .empty_o (o_rx_empty),
    .level_o (o_rx_level)
  );

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Scoreboard bench for spi_xfer_sequencer: directed vectors push expectations
// into queues, a negedge monitor pops and compares whenever the DUT presents data.
module tb_spi_xfer_sequencer;

  localparam int CW = 2;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_tx_wr = 1'b0;
  logic [7:0]    i_tx_data = 8'h00;
  logic          o_tx_full;
  logic [LW-1:0] o_tx_level;
  logic          i_start = 1'b0;
  logic [CW-1:0] i_len = '0;
  logic          o_busy, o_done, o_err;
  logic          i_rx_rd = 1'b0;
  logic [7:0]    o_rx_data;
  logic          o_rx_empty;
  logic [LW-1:0] o_rx_level;
  logic          o_rx_ovf;
  logic [CW-1:0] o_MOSI_Count;
  logic [7:0]    o_MOSI_Byte;
  logic          o_MOSI_DV;
  logic          i_MOSI_Ready = 1'b1;
  logic          i_MISO_DV = 1'b0;
  logic [7:0]    i_MISO_Byte = 8'h00;

  spi_xfer_sequencer #(
    .MAX_BYTES_PER_CS (2),
    .FIFO_DEPTH       (8),
    .TIMEOUT_CLKS     (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_tx_wr      (i_tx_wr),
    .i_tx_data    (i_tx_data),
    .o_tx_full    (o_tx_full),
    .o_tx_level   (o_tx_level),
    .i_start      (i_start),
    .i_len        (i_len),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .i_rx_rd      (i_rx_rd),
    .o_rx_data    (o_rx_data),
    .o_rx_empty   (o_rx_empty),
    .o_rx_level   (o_rx_level),
    .o_rx_ovf     (o_rx_ovf),
    .o_MOSI_Count (o_MOSI_Count),
    .o_MOSI_Byte  (o_MOSI_Byte),
    .o_MOSI_DV    (o_MOSI_DV),
    .i_MOSI_Ready (i_MOSI_Ready),
    .i_MISO_DV    (i_MISO_DV),
    .i_MISO_Byte  (i_MISO_Byte)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_mosi[$];
  logic [7:0] exp_rx[$];
  logic [7:0] miso_resp[$];
  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  int dv_cnt = 0, done_cnt = 0, err_cnt = 0;
  int cyc = 0, last_ev_cyc = 0, err_cyc = 0;
  bit dv_prev = 1'b0, done_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      dv_prev   = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (o_MOSI_DV) begin
        dv_cnt++;
        last_ev_cyc = cyc;
        chk("dv_gap", {31'd0, dv_prev}, 32'd0);
        chk("mosi_count", {30'd0, o_MOSI_Count}, exp_count);
        if (exp_mosi.size() == 0) chk("mosi_unexpected", {24'd0, o_MOSI_Byte}, 32'hFFFF_FFFF);
        else chk("mosi_byte", {24'd0, o_MOSI_Byte}, {24'd0, exp_mosi.pop_front()});
      end
      if (o_done) begin
        done_cnt++;
        chk("busy_at_done", {31'd0, o_busy}, 32'd1);
      end
      if (done_prev) chk("busy_after_done", {31'd0, o_busy}, 32'd0);
      if (o_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (i_rx_rd && !o_rx_empty) begin
        if (exp_rx.size() == 0) chk("rx_unexpected", {24'd0, o_rx_data}, 32'hFFFF_FFFF);
        else chk("rx_data", {24'd0, o_rx_data}, {24'd0, exp_rx.pop_front()});
      end
      dv_prev   = o_MOSI_DV;
      done_prev = o_done;
    end
  end

  // Wrapper model: answers each MOSI byte with the next queued MISO byte.
  initial begin
    forever begin
      @(negedge clk);
      i_MISO_DV = 1'b0;
      if (rst_n && o_MOSI_DV && miso_resp.size() > 0) begin
        i_MISO_DV   = 1'b1;
        i_MISO_Byte = miso_resp.pop_front();
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic push_tx(input logic [7:0] b);
    i_tx_wr   = 1'b1;
    i_tx_data = b;
    tick();
    i_tx_wr   = 1'b0;
  endtask

  task automatic start_pulse(input int len);
    i_start = 1'b1;
    i_len   = CW'(len);
    tick();
    i_start = 1'b0;
    i_len   = '0;
  endtask

  task automatic read_rx(input int n);
    i_rx_rd = 1'b1;
    repeat (n) tick();
    i_rx_rd = 1'b0;
  endtask

  task automatic check_reset(input string name);
    chk({name, "_ctrl"},
        {15'd0, o_busy, o_done, o_err, o_tx_full, o_tx_level, o_rx_empty,
         o_rx_level, o_rx_ovf, o_MOSI_DV, o_MOSI_Count},
        {15'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 2'd0});
    chk({name, "_data"}, {16'd0, o_MOSI_Byte, o_rx_data}, 32'd0);
  endtask

  task automatic wait_done(input int d0);
    for (int k = 0; k < 50 && done_cnt == d0; k++) tick();
    chk("xfer_done", done_cnt, d0 + 1);
    tick();
  endtask

  task automatic xfer(input int len, input logic [7:0] t0, t1, r0, r1, input bit keep);
    int d0;
    d0 = done_cnt;
    exp_count = len;
    exp_mosi.push_back(t0);
    miso_resp.push_back(r0);
    if (keep) exp_rx.push_back(r0);
    if (len == 2) begin
      exp_mosi.push_back(t1);
      miso_resp.push_back(r1);
      if (keep) exp_rx.push_back(r1);
    end
    start_pulse(len);
    wait_done(d0);
  endtask

  initial begin
    int bad_len[3];
    int e0, v0, d0, s_cyc;
    bad_len = '{0, 3, 2};

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    tick();

    // Basic two-byte transfer
    push_tx(8'hA5);
    push_tx(8'h3C);
    chk("t1_tx_level", o_tx_level, 2);
    v0 = dv_cnt;
    xfer(2, 8'hA5, 8'h3C, 8'h11, 8'h22, 1'b1);
    chk("t1_dv_cnt", dv_cnt, v0 + 2);
    chk("t1_tx_level_after", o_tx_level, 0);
    chk("t1_rx_level", o_rx_level, 2);
    read_rx(2);
    chk("t1_rx_empty", o_rx_empty, 1);

    // Rejected starts
    push_tx(8'h77);
    for (int i = 0; i < 3; i++) begin
      e0 = err_cnt;
      v0 = dv_cnt;
      start_pulse(bad_len[i]);
      repeat (3) tick();
      chk("rej_err", err_cnt, e0 + 1);
      chk("rej_no_dv", dv_cnt, v0);
      chk("rej_tx_level", o_tx_level, 1);
      chk("rej_busy", o_busy, 0);
    end

    // Fill TX, push-when-full ignored, fill RX, then overflow
    for (int i = 1; i <= 7; i++) push_tx(8'(i));
    chk("tx_full", o_tx_full, 1);
    push_tx(8'hEE);
    chk("tx_full_level", o_tx_level, 8);
    xfer(2, 8'h77, 8'h01, 8'h80, 8'h81, 1'b1);
    xfer(2, 8'h02, 8'h03, 8'h82, 8'h83, 1'b1);
    xfer(2, 8'h04, 8'h05, 8'h84, 8'h85, 1'b1);
    xfer(2, 8'h06, 8'h07, 8'h86, 8'h87, 1'b1);
    chk("rx_fill_level", o_rx_level, 8);
    chk("rx_no_ovf_yet", o_rx_ovf, 0);
    push_tx(8'h08);
    xfer(1, 8'h08, 8'h00, 8'h88, 8'h00, 1'b0);
    chk("rx_ovf_set", o_rx_ovf, 1);
    chk("rx_ovf_level", o_rx_level, 8);
    read_rx(8);
    chk("rx_drained", o_rx_empty, 1);

    // Full TX with simultaneous push and DV pop
    for (int i = 0; i < 8; i++) push_tx(8'h10 + 8'(i));
    chk("tx_full2", o_tx_full, 1);
    d0 = done_cnt;
    exp_count = 1;
    exp_mosi.push_back(8'h10);
    miso_resp.push_back(8'h99);
    exp_rx.push_back(8'h99);
    start_pulse(1);
    chk("simul_dv", o_MOSI_DV, 1);
    i_tx_wr   = 1'b1;
    i_tx_data = 8'h18;
    tick();
    i_tx_wr   = 1'b0;
    chk("simul_level", o_tx_level, 8);
    wait_done(d0);
    chk("ovf_cleared", o_rx_ovf, 0);
    read_rx(1);
    xfer(2, 8'h11, 8'h12, 8'hA0, 8'hA1, 1'b1);
    xfer(2, 8'h13, 8'h14, 8'hA2, 8'hA3, 1'b1);
    xfer(2, 8'h15, 8'h16, 8'hA4, 8'hA5, 1'b1);
    xfer(2, 8'h17, 8'h18, 8'hA6, 8'hA7, 1'b1);
    read_rx(8);
    chk("order_tx_empty", o_tx_level, 0);

    // Reset after the first of two bytes
    push_tx(8'hAA);
    push_tx(8'hBB);
    exp_count = 2;
    exp_mosi.push_back(8'hAA);
    v0 = dv_cnt;
    start_pulse(2);
    for (int k = 0; k < 20 && dv_cnt == v0; k++) begin
      @(negedge clk);
      #1;
    end
    chk("mid_first_dv", dv_cnt, v0 + 1);
    tick();
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    tick();
    rst_n = 1'b1;
    tick();

    push_tx(8'h5A);
    xfer(1, 8'h5A, 8'h00, 8'hC3, 8'h00, 1'b1);
    read_rx(1);

`ifdef SPI_SEQ_TIMEOUT_EN
    // Watchdog: no MISO response after both bytes sent
    push_tx(8'hC1);
    push_tx(8'hC2);
    push_tx(8'hC3);
    exp_count = 2;
    exp_mosi.push_back(8'hC1);
    exp_mosi.push_back(8'hC2);
    e0 = err_cnt;
    d0 = done_cnt;
    v0 = dv_cnt;
    start_pulse(2);
    for (int k = 0; k < 60 && err_cnt == e0; k++) tick();
    chk("to_err", err_cnt, e0 + 1);
    chk("to_dv_cnt", dv_cnt, v0 + 2);
    chk("to_delay", err_cyc - last_ev_cyc, 16);
    tick();
    chk("to_no_done", done_cnt, d0);
    chk("to_idle", o_busy, 0);
    chk("to_tx_level", o_tx_level, 1);
    chk("to_tx_head", o_MOSI_Byte, 8'hC3);

    // Watchdog with Ready low: both bytes of this transfer are flushed
    push_tx(8'hD1);
    push_tx(8'hD2);
    i_MOSI_Ready = 1'b0;
    e0 = err_cnt;
    v0 = dv_cnt;
    exp_count = 2;
    start_pulse(2);
    s_cyc = cyc;
    for (int k = 0; k < 60 && err_cnt == e0; k++) tick();
    chk("flush_err", err_cnt, e0 + 1);
    chk("flush_delay", err_cyc - s_cyc, 16);
    chk("flush_no_dv", dv_cnt, v0);
    tick();
    chk("flush_idle", o_busy, 0);
    chk("flush_tx_level", o_tx_level, 1);
    chk("flush_tx_head", o_MOSI_Byte, 8'hD2);
    i_MOSI_Ready = 1'b1;
`endif

    chk("mosi_queue_left", exp_mosi.size(), 0);
    chk("rx_queue_left", exp_rx.size(), 0);
    chk("miso_queue_left", miso_resp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
